// File: rtl/edge_pkg.sv
// edge_pkg: shared types and constants for the edge-detector pipeline control.
//   ctrl_state_t : shift_path_ctrl FSM states
//   WORD_W       : image word width (4 pixels x 8 bits)
//   WIN_ROWS     : rows per Sobel window (one fetch lane per row)
//   WIN_COLS     : words per Sobel window row
package edge_pkg;

    localparam int WORD_W   = 32;
    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FLUSH,
        WIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/shift_addr_gen.sv
// shift_addr_gen: row-band / column / lane counters and word address for the frame walk.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : zero all counters (frame start)
//   step_lane      : next lane (row r+k+1) of the current column
//   step_col       : next column, lane 0
//   step_row       : next row band, column 0, lane 0
//   mem_addr       : (r+k)*IMG_W_WORDS + c
//   row, col       : current r, c
//   last_lane/col/row : k, c, r at their final values
module shift_addr_gen
    import edge_pkg::*;
#(
    parameter int IMG_W_WORDS = 80,
    parameter int IMG_H       = 240,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step_lane,
    input  logic              step_col,
    input  logic              step_row,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic              last_lane,
    output logic              last_col,
    output logic              last_row
);

    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(IMG_W_WORDS);
    localparam logic [15:0]       LAST_COL = 16'(IMG_W_WORDS - 1);
    localparam logic [15:0]       LAST_ROW = 16'(IMG_H - WIN_ROWS);
    localparam logic [1:0]        LAST_K   = 2'(WIN_ROWS - 1);

    logic [15:0]       r_d, r_q, c_d, c_q;
    logic [1:0]        k_d, k_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    // base_q tracks r*IMG_W_WORDS so addresses are formed by addition only
    logic [ADDR_W-1:0] base_d, base_q;

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        k_d    = k_q;
        addr_d = addr_q;
        base_d = base_q;
        if (clear) begin
            r_d    = '0;
            c_d    = '0;
            k_d    = '0;
            addr_d = '0;
            base_d = '0;
        end else if (step_row) begin
            r_d    = r_q + 16'd1;
            c_d    = '0;
            k_d    = '0;
            base_d = base_q + STRIDE;
            addr_d = base_q + STRIDE;
        end else if (step_col) begin
            c_d    = c_q + 16'd1;
            k_d    = '0;
            addr_d = base_q + ADDR_W'(c_q + 16'd1);
        end else if (step_lane) begin
            k_d    = k_q + 2'd1;
            addr_d = addr_q + STRIDE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            c_q    <= '0;
            k_q    <= '0;
            addr_q <= '0;
            base_q <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            k_q    <= k_d;
            addr_q <= addr_d;
            base_q <= base_d;
        end
    end

    assign mem_addr  = addr_q;
    assign row       = r_q;
    assign col       = c_q;
    assign last_lane = k_q == LAST_K;
    assign last_col  = c_q == LAST_COL;
    assign last_row  = r_q == LAST_ROW;

endmodule

// File: rtl/shift_path_ctrl.sv
// shift_path_ctrl: sequences frame-memory reads into shift_data_path and flags complete 3x2 windows.
//   clk, rst              : clock, synchronous active-high reset
//   start / busy / done   : frame handshake (start sampled in IDLE, done one-cycle pulse)
//   mem_req/addr/ack/rdata: word read port, request held until ack
//   dp_write_en, dp_data  : datapath shift strobe and word, one cycle after each ack
//   win_valid, win_ack    : window handshake to the Sobel stage
//   win_row, win_col      : top row and right-hand word column of the current window
module shift_path_ctrl
    import edge_pkg::*;
#(
    parameter int IMG_W_WORDS = 80,
    parameter int IMG_H       = 240,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              dp_write_en,
    output logic [WORD_W-1:0] dp_data,
    output logic              win_valid,
    input  logic              win_ack,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col
);

    if (IMG_W_WORDS < WIN_COLS) begin : g_bad_w
        $error("shift_path_ctrl: IMG_W_WORDS must be >= 2");
    end
    if (IMG_H < WIN_ROWS) begin : g_bad_h
        $error("shift_path_ctrl: IMG_H must be >= 3");
    end
    if (longint'(IMG_W_WORDS) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_a
        $error("shift_path_ctrl: frame does not fit in ADDR_W address bits");
    end

    ctrl_state_t       state_d, state_q;
    logic              dp_we_d, dp_we_q;
    logic [WORD_W-1:0] dp_data_d, dp_data_q;
    logic              clear, step_lane, step_col, step_row;
    logic              last_lane, last_col, last_row;
    logic [15:0]       row, col;

    shift_addr_gen #(
        .IMG_W_WORDS(IMG_W_WORDS),
        .IMG_H      (IMG_H),
        .ADDR_W     (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .step_lane(step_lane),
        .step_col (step_col),
        .step_row (step_row),
        .mem_addr (mem_addr),
        .row      (row),
        .col      (col),
        .last_lane(last_lane),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        step_lane = 1'b0;
        step_col  = 1'b0;
        step_row  = 1'b0;
        dp_we_d   = 1'b0;
        dp_data_d = dp_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    dp_we_d   = 1'b1;
                    dp_data_d = mem_rdata;
                    if (last_lane) state_d = FLUSH;
                    else           step_lane = 1'b1;
                end
            end
            // The first column of a band only primes the datapath; no window yet.
            FLUSH: begin
                if (col == 16'd0) begin
                    step_col = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = WIN;
                end
            end
            WIN: begin
                if (win_ack) begin
                    if (!last_col) begin
                        step_col = 1'b1;
                        state_d  = FETCH;
                    end else if (!last_row) begin
                        step_row = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dp_we_q   <= 1'b0;
            dp_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dp_we_q   <= dp_we_d;
            dp_data_q <= dp_data_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign mem_req     = state_q == FETCH;
    assign win_valid   = state_q == WIN;
    assign dp_write_en = dp_we_q;
    assign dp_data     = dp_data_q;
    assign win_row     = row;
    assign win_col     = col;

endmodule

// File: tb/tb_shift_path_ctrl.sv
// tb_shift_path_ctrl: scoreboard bench for shift_path_ctrl on a 3-word x 4-row frame.
module tb_shift_path_ctrl;

    localparam int W  = 3;
    localparam int H  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst, start, mem_ack, win_ack;
    logic [31:0]   mem_rdata;
    logic          busy, done, mem_req, dp_write_en, win_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   dp_data;
    logic [15:0]   win_row, win_col;

    shift_path_ctrl #(.IMG_W_WORDS(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dp_write_en(dp_write_en),
        .dp_data    (dp_data),
        .win_valid  (win_valid),
        .win_ack    (win_ack),
        .win_row    (win_row),
        .win_col    (win_col)
    );

    always #5 clk = ~clk;

    typedef struct {int r; int c;} win_t;

    int   checks = 0, failures = 0;
    int   addr_q[$], data_q[$];
    win_t win_q[$];
    int   shreg[6];
    int   exp_w[6] = '{0, 3, 6, 1, 4, 7};
    int   n_reads, n_win, n_done, max_dly, bp_left, wait_cnt, pend_addr, cur_r, cur_c;
    bit   pending, win_open, pv_valid, pv_done, chk_w;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load();
        addr_q.delete();
        data_q.delete();
        win_q.delete();
        for (int r = 0; r <= H - 3; r++)
            for (int c = 0; c < W; c++) begin
                for (int k = 0; k < 3; k++) addr_q.push_back((r + k) * W + c);
                if (c > 0) win_q.push_back('{r, c});
            end
        for (int i = 0; i < 6; i++) shreg[i] = 0;
        pending  = 0;
        win_open = 0;
        n_reads  = 0;
        n_win    = 0;
        n_done   = 0;
    endtask

    // One clock: sample #1 after the edge, score outputs, then drive the
    // memory and window responders for the next edge.
    task automatic step();
        logic ack_e, rst_e, wack_e;
        win_t w;
        @(posedge clk);
        #1;
        ack_e   = mem_ack;
        rst_e   = rst;
        wack_e  = win_ack && pv_valid;
        mem_ack = 1'b0;
        chk("dp_write_en", dp_write_en, 32'(ack_e && !rst_e));
        if (dp_write_en) begin
            chk("data_q_nonempty", 32'(data_q.size() != 0), 1);
            if (data_q.size() != 0) chk("dp_data", dp_data, data_q.pop_front());
            for (int i = 0; i < 5; i++) shreg[i] = shreg[i + 1];
            shreg[5] = int'(dp_data);
        end
        if (rst_e) begin
            pending  = 0;
            win_open = 0;
            data_q.delete();
        end
        if (win_open) begin
            if (wack_e) begin
                chk("win_drop", 32'(win_valid), 0);
                win_open = 0;
            end else begin
                chk("win_hold_valid", 32'(win_valid), 1);
                chk("win_hold_row", win_row, cur_r);
                chk("win_hold_col", win_col, cur_c);
                chk("win_hold_req", 32'(mem_req), 0);
                chk("win_hold_we", 32'(dp_write_en), 0);
            end
        end else if (win_valid) begin
            chk("win_q_nonempty", 32'(win_q.size() != 0), 1);
            if (win_q.size() != 0) begin
                w = win_q.pop_front();
                chk("win_row", win_row, w.r);
                chk("win_col", win_col, w.c);
            end
            if (chk_w && n_win == 0)
                for (int i = 0; i < 6; i++) chk($sformatf("w%0d", i), shreg[i], exp_w[i]);
            win_open = 1;
            cur_r    = int'(win_row);
            cur_c    = int'(win_col);
            n_win++;
        end
        win_ack = win_valid ? (bp_left == 0) : 1'b1;
        if (win_valid && bp_left > 0) bp_left--;
        if (mem_req && !rst_e) begin
            if (!pending) begin
                pending   = 1;
                pend_addr = int'(mem_addr);
                n_reads++;
                chk("addr_q_nonempty", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) chk("mem_addr", mem_addr, addr_q.pop_front());
                wait_cnt = int'($urandom_range(max_dly, 0));
            end else begin
                chk("addr_stable", mem_addr, pend_addr);
            end
            if (wait_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'(mem_addr);
                data_q.push_back(int'(mem_addr));
                pending   = 0;
            end else begin
                wait_cnt--;
            end
        end
        if (done) begin
            chk("done_one_cycle", 32'(pv_done), 0);
            n_done++;
        end
        pv_valid = win_valid;
        pv_done  = done;
    endtask

    task automatic run_frame(int dly, int bp, bit extra, bit wchk);
        load();
        max_dly = dly;
        bp_left = bp;
        chk_w   = wchk;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("busy_start", 32'(busy), 1);
        chk("first_addr", mem_addr, 0);
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            if (extra && i == 12) start = 1'b1;
            step();
            start = 1'b0;
        end
        repeat (3) step();
        chk("busy_after", 32'(busy), 0);
        chk("n_done", n_done, 1);
        chk("n_reads", n_reads, 3 * W * (H - 2));
        chk("n_win", n_win, (W - 1) * (H - 2));
        chk("addr_left", addr_q.size(), 0);
        chk("win_left", win_q.size(), 0);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_we"}, 32'(dp_write_en), 0);
        chk({tag, "_data"}, dp_data, 0);
        chk({tag, "_wv"}, 32'(win_valid), 0);
        chk({tag, "_row"}, win_row, 0);
        chk({tag, "_col"}, win_col, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        win_ack   = 1'b1;
        max_dly   = 0;
        bp_left   = 0;
        chk_w     = 0;
        load();
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        step();

        run_frame(0, 0, 0, 1);
        run_frame(0, 10, 0, 0);
        run_frame(4, 0, 0, 0);
        run_frame(0, 0, 1, 0);

        load();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3000 && !(n_win >= 2 && !win_open && mem_req); i++) step();
        chk("band2_reached", n_win, 2);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hdead_beef;
        step();
        rst = 1'b0;
        chk_idle("midrst");
        repeat (4) step();
        chk("midrst_no_done", n_done, 0);
        chk("midrst_idle", 32'(busy), 0);
        run_frame(0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
